// File: rtl/lbu_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// lbu_ptr_ctrl - loop-buffer pointer controller
//
// Holds NUM_ID pointer contexts, each with start, end, stride and ptr (plus a
// per-context wrap-enable when the wrap feature is built in). An lbset
// instruction loads a context and rewinds its pointer to start. A pointer
// operation (NONE/RST/INCR/DECR) updates one context's pointer and presents
// the new value on a valid/ready result channel one cycle later.
//
// Optional feature macro: LBU_PTR_WRAP_EN
//   defined   - INCR/DECR results outside [start, end] wrap when wa=1
//   undefined - no wa storage, no comparators, plain modulo arithmetic
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   lbset_valid                lbset strobe (always accepted)
//   lbset_id/start/end/stride/wa   lbset payload
//   op_valid, op_ready         pointer-operation handshake
//   op_id, op_mode             target context, 0=NONE 1=RST 2=INCR 3=DECR
//   ptr_valid, ptr_ready       result handshake
//   ptr_id, ptr_value          result context and updated pointer (signed)
//   err_op                     sticky flag, set by op_mode 4..7
// ---------------------------------------------------------------------------
module lbu_ptr_ctrl #(
    parameter int NUM_ID   = 4,
    parameter int ID_W     = 2,
    parameter int PTR_W    = 24,
    parameter int STRIDE_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lbset_valid,
    input  logic [ID_W-1:0]            lbset_id,
    input  logic signed [PTR_W-1:0]    lbset_start,
    input  logic signed [PTR_W-1:0]    lbset_end,
    input  logic signed [STRIDE_W-1:0] lbset_stride,
    input  logic                       lbset_wa,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [ID_W-1:0]            op_id,
    input  logic [2:0]                 op_mode,
    output logic                       ptr_valid,
    input  logic                       ptr_ready,
    output logic [ID_W-1:0]            ptr_id,
    output logic signed [PTR_W-1:0]    ptr_value,
    output logic                       err_op
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_RST  = 3'd1,
        OP_INCR = 3'd2,
        OP_DECR = 3'd3
    } op_mode_e;

    logic signed [PTR_W-1:0]    start_q  [NUM_ID];
    logic signed [PTR_W-1:0]    end_q    [NUM_ID];
    logic signed [STRIDE_W-1:0] stride_q [NUM_ID];
    logic signed [PTR_W-1:0]    ptr_q    [NUM_ID];

    logic                       accept_p0;
    logic                       illegal_p0;
    logic signed [PTR_W:0]      cur_w_p0;
    logic signed [PTR_W:0]      stride_w_p0;
    logic signed [PTR_W:0]      sum_w_p0;
    logic signed [PTR_W-1:0]    new_ptr_p0;

`ifdef LBU_PTR_WRAP_EN
    logic                       wa_q [NUM_ID];

    // Compare at PTR_W+1 bits so an INCR/DECR that overflows PTR_W is still
    // ordered correctly against start/end. Values equal to a bound are kept.
    function automatic logic signed [PTR_W-1:0] wrap_ptr(
        input logic signed [PTR_W:0]   sum_w,
        input logic signed [PTR_W-1:0] lo,
        input logic signed [PTR_W-1:0] hi
    );
        logic signed [PTR_W:0] lo_w;
        logic signed [PTR_W:0] hi_w;
        lo_w = {lo[PTR_W-1], lo};
        hi_w = {hi[PTR_W-1], hi};
        if (sum_w > hi_w)
            return lo;
        else if (sum_w < lo_w)
            return hi;
        else
            return sum_w[PTR_W-1:0];
    endfunction
`else
    logic unused_wa;
    logic unused_sum_msb;
    assign unused_wa      = lbset_wa;
    assign unused_sum_msb = sum_w_p0[PTR_W];
`endif

    // lbset owns a context for the cycle it writes it, so a same-ID op waits.
    assign op_ready   = !(ptr_valid && !ptr_ready) &&
                        !(lbset_valid && (lbset_id == op_id));
    assign accept_p0  = op_valid && op_ready;
    assign illegal_p0 = op_mode[2];

    always_comb begin
        cur_w_p0    = {ptr_q[op_id][PTR_W-1], ptr_q[op_id]};
        stride_w_p0 = {{(PTR_W+1-STRIDE_W){stride_q[op_id][STRIDE_W-1]}},
                       stride_q[op_id]};
        sum_w_p0    = cur_w_p0;
        case (op_mode)
            OP_RST:  sum_w_p0 = {start_q[op_id][PTR_W-1], start_q[op_id]};
            OP_INCR: sum_w_p0 = cur_w_p0 + stride_w_p0;
            OP_DECR: sum_w_p0 = cur_w_p0 - stride_w_p0;
            default: sum_w_p0 = cur_w_p0;
        endcase
        new_ptr_p0 = sum_w_p0[PTR_W-1:0];
`ifdef LBU_PTR_WRAP_EN
        if (wa_q[op_id] && ((op_mode == OP_INCR) || (op_mode == OP_DECR)))
            new_ptr_p0 = wrap_ptr(sum_w_p0, start_q[op_id], end_q[op_id]);
`endif
    end

    // ---- stage p0 -> p1: context state and result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ID; i++) begin
                start_q[i]  <= '0;
                end_q[i]    <= '0;
                stride_q[i] <= '0;
                ptr_q[i]    <= '0;
`ifdef LBU_PTR_WRAP_EN
                wa_q[i]     <= 1'b0;
`endif
            end
            ptr_valid <= 1'b0;
            ptr_id    <= '0;
            ptr_value <= '0;
            err_op    <= 1'b0;
        end else begin
            if (lbset_valid) begin
                start_q[lbset_id]  <= lbset_start;
                end_q[lbset_id]    <= lbset_end;
                stride_q[lbset_id] <= lbset_stride;
                ptr_q[lbset_id]    <= lbset_start;
`ifdef LBU_PTR_WRAP_EN
                wa_q[lbset_id]     <= lbset_wa;
`endif
            end
            if (accept_p0) begin
                ptr_q[op_id] <= new_ptr_p0;
                ptr_value    <= new_ptr_p0;
                ptr_id       <= op_id;
                ptr_valid    <= 1'b1;
                if (illegal_p0)
                    err_op <= 1'b1;
            end else if (ptr_ready) begin
                ptr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lbu_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lbu_ptr_ctrl - directed self-checking bench for lbu_ptr_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// updates on the rising edge. Expected values are hand-computed constants,
// with the wrap-dependent ones selected by LBU_PTR_WRAP_EN.
// ---------------------------------------------------------------------------
module tb_lbu_ptr_ctrl;

    localparam int NUM_ID   = 4;
    localparam int ID_W     = 2;
    localparam int PTR_W    = 24;
    localparam int STRIDE_W = 8;

`ifdef LBU_PTR_WRAP_EN
    localparam logic [23:0] EXP_ID1_4TH  = 24'd100;
    localparam logic [23:0] EXP_ID2_INCR = 24'd80;
`else
    localparam logic [23:0] EXP_ID1_4TH  = 24'd140;
    localparam logic [23:0] EXP_ID2_INCR = 24'd30;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       lbset_valid;
    logic [ID_W-1:0]            lbset_id;
    logic signed [PTR_W-1:0]    lbset_start;
    logic signed [PTR_W-1:0]    lbset_end;
    logic signed [STRIDE_W-1:0] lbset_stride;
    logic                       lbset_wa;
    logic                       op_valid;
    logic                       op_ready;
    logic [ID_W-1:0]            op_id;
    logic [2:0]                 op_mode;
    logic                       ptr_valid;
    logic                       ptr_ready;
    logic [ID_W-1:0]            ptr_id;
    logic signed [PTR_W-1:0]    ptr_value;
    logic                       err_op;

    int checks = 0;
    int errors = 0;

    lbu_ptr_ctrl #(
        .NUM_ID(NUM_ID), .ID_W(ID_W), .PTR_W(PTR_W), .STRIDE_W(STRIDE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lbset_valid(lbset_valid), .lbset_id(lbset_id),
        .lbset_start(lbset_start), .lbset_end(lbset_end),
        .lbset_stride(lbset_stride), .lbset_wa(lbset_wa),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_id(op_id), .op_mode(op_mode),
        .ptr_valid(ptr_valid), .ptr_ready(ptr_ready),
        .ptr_id(ptr_id), .ptr_value(ptr_value), .err_op(err_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic lbset(input logic [ID_W-1:0] id, input int s, input int e,
                         input int st, input logic wa);
        lbset_valid  = 1'b1;
        lbset_id     = id;
        lbset_start  = PTR_W'(s);
        lbset_end    = PTR_W'(e);
        lbset_stride = STRIDE_W'(st);
        lbset_wa     = wa;
    endtask

    initial begin
        rst_n = 1'b0; lbset_valid = 1'b0; lbset_id = '0; lbset_start = '0;
        lbset_end = '0; lbset_stride = '0; lbset_wa = 1'b0;
        op_valid = 1'b0; op_id = '0; op_mode = 3'd0; ptr_ready = 1'b1;

        // Reset state
        @(negedge clk); #1;
        check("rst_ptr_valid", ptr_valid, 24'd0);
        check("rst_ptr_value", ptr_value, 24'd0);
        check("rst_ptr_id",    ptr_id,    24'd0);
        check("rst_err_op",    err_op,    24'd0);
        check("rst_op_ready",  op_ready,  24'd1);
        @(negedge clk); rst_n = 1'b1;

        // id1: start=100 end=130 stride=10 wa=1, four back-to-back INCR
        @(negedge clk); lbset(2'd1, 100, 130, 10, 1'b1);
        @(negedge clk); lbset_valid = 1'b0;
        op_valid = 1'b1; op_id = 2'd1; op_mode = 3'd2; #1;
        check("id1_op_ready", op_ready, 24'd1);
        @(negedge clk); check("id1_incr1", ptr_value, 24'd110);
        check("id1_ptr_id", ptr_id, 24'd1);
        check("id1_ptr_valid", ptr_valid, 24'd1);
        @(negedge clk); check("id1_incr2", ptr_value, 24'd120);
        @(negedge clk); check("id1_incr3", ptr_value, 24'd130);
        @(negedge clk); check("id1_incr4", ptr_value, EXP_ID1_4TH);
        op_valid = 1'b0;
        @(negedge clk); check("valid_clears", ptr_valid, 24'd0);

        // id2: start=50 end=80 stride=-20 wa=1, INCR then DECR
        lbset(2'd2, 50, 80, -20, 1'b1);
        @(negedge clk); lbset_valid = 1'b0;
        op_valid = 1'b1; op_id = 2'd2; op_mode = 3'd2;
        @(negedge clk); check("id2_incr", ptr_value, EXP_ID2_INCR);
        op_mode = 3'd3;
        @(negedge clk); check("id2_decr", ptr_value, 24'd50);
        check("id2_ptr_id", ptr_id, 24'd2);

        // Back-pressure: result pending, ptr_ready low for 3 cycles
        ptr_ready = 1'b0; op_id = 2'd1; op_mode = 3'd1; #1;
        check("bp_op_ready0", op_ready, 24'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_op_ready", op_ready, 24'd0);
            check("bp_hold_value", ptr_value, 24'd50);
            check("bp_hold_id", ptr_id, 24'd2);
            check("bp_hold_valid", ptr_valid, 24'd1);
        end
        ptr_ready = 1'b1; #1;
        check("bp_op_ready1", op_ready, 24'd1);
        @(negedge clk); check("bp_rst_result", ptr_value, 24'd100);
        check("bp_rst_id", ptr_id, 24'd1);
        op_valid = 1'b0;

        // Same-cycle lbset and op on id3: lbset wins, op sees new start
        @(negedge clk); lbset(2'd3, 200, 300, 5, 1'b0);
        op_valid = 1'b1; op_id = 2'd3; op_mode = 3'd1; #1;
        check("conflict_op_ready", op_ready, 24'd0);
        @(negedge clk); lbset_valid = 1'b0; #1;
        check("conflict_no_accept", ptr_valid, 24'd0);
        check("conflict_ready_next", op_ready, 24'd1);
        @(negedge clk); check("conflict_new_start", ptr_value, 24'd200);
        check("conflict_ptr_id", ptr_id, 24'd3);
        op_valid = 1'b0;

        // Illegal op_mode 5 on id1 (ptr=100): unchanged, err_op sticky
        @(negedge clk); op_valid = 1'b1; op_id = 2'd1; op_mode = 3'd5;
        @(negedge clk); check("illegal_value", ptr_value, 24'd100);
        check("illegal_valid", ptr_valid, 24'd1);
        check("illegal_err", err_op, 24'd1);
        op_valid = 1'b0; ptr_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check("err_sticky", err_op, 24'd1);
        check("pending_before_rst", ptr_valid, 24'd1);
        rst_n = 1'b0; #1;
        check("rst_clears_err", err_op, 24'd0);
        check("rst_discards", ptr_valid, 24'd0);
        check("rst_op_ready_bp", op_ready, 24'd1);
        @(negedge clk); rst_n = 1'b1; ptr_ready = 1'b1;

        // Modulo overflow with wa=0: 0x7FFFFF + 1 -> 0x800000
        @(negedge clk); lbset(2'd0, 24'h7FFFFF, 0, 1, 1'b0);
        @(negedge clk); lbset_valid = 1'b0;
        op_valid = 1'b1; op_id = 2'd0; op_mode = 3'd2;
        @(negedge clk); check("overflow", ptr_value, 24'h800000);
        op_valid = 1'b0; ptr_ready = 1'b0;

        // lbset to a context with a pending result leaves ptr_value alone
        lbset(2'd0, 5, 9, 1, 1'b0);
        @(negedge clk); lbset_valid = 1'b0;
        check("lbset_pending_hold", ptr_value, 24'h800000);
        ptr_ready = 1'b1; op_valid = 1'b1; op_id = 2'd0; op_mode = 3'd0;
        @(negedge clk); check("none_after_lbset", ptr_value, 24'd5);
        op_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
